fpga_status_leds: RTL and testbench
===================================

FPGA_STATUS_LEDS -- requirements
Module: fpga_status_leds

Interface
REQ-001 Parameter NUM_LEDS, default 4: number of independent LED channels, legal range 1..16.
REQ-002 Parameter DIV_W, default 27: width of the tick prescaler counter and of cfg_div_i.
REQ-003 Parameter STRETCH_W, default 4: width of each per-channel stretch counter.
REQ-004 Parameter STRETCH_TICKS, default 8: reload value of the stretch counter, in ticks, legal range 1..2^STRETCH_W-1.
REQ-005 Port clk_i, input, 1: the block's single clock.
REQ-006 Port rst_ni, input, 1: asynchronous active-low reset.
REQ-007 Port cfg_mode_i, input, 2*NUM_LEDS: per-channel mode, channel k at bits [2k+1:2k]; 00 = OFF, 01 = ON, 10 = BLINK, 11 = STRETCH.
REQ-008 Port cfg_div_i, input, DIV_W: tick period minus one, in clk_i cycles.
REQ-009 Port event_i, input, NUM_LEDS: per-channel event strobes, sampled every cycle.
REQ-010 Port exit_valid_i, input, 1: program-exit strobe.
REQ-011 Port exit_value_i, input, 32: program exit value, sampled when exit_valid_i is high.
REQ-012 Port led_o, output, NUM_LEDS: registered LED drives.
REQ-013 Port heartbeat_o, output, 1: registered blink phase, independent of mode.
REQ-014 Port exit_latched_o, output, 1: sticky flag set by exit_valid_i.

Function
REQ-015 The prescaler shall count up by 1 per cycle and assert an internal tick for one cycle when count >= cfg_div_i, with the count returning to 0 in the following cycle.
REQ-016 With cfg_div_i = 0, tick shall be asserted every cycle; when cfg_div_i is lowered below the current count, tick shall fire in the next cycle.
REQ-017 The phase register shall toggle on every tick; heartbeat_o shall equal phase.
REQ-018 Per channel, the next LED value shall be: OFF -> 0; ON -> 1; BLINK -> phase; STRETCH -> (stretch counter != 0).
REQ-019 In STRETCH mode, event_i[k] high shall load counter k with STRETCH_TICKS; otherwise a tick shall decrement a nonzero counter; the counter shall saturate at 0.
REQ-020 When event_i[k] and a tick coincide, the reload shall win and no decrement shall occur that cycle.
REQ-021 A retrigger while the counter is nonzero shall reload it to STRETCH_TICKS, extending the pulse.
REQ-022 In any mode other than STRETCH, counter k shall be held at 0, and event_i[k] shall be ignored.
REQ-023 led_o shall be registered: a mode, phase or counter change shall appear on led_o exactly 1 cycle later.
REQ-024 exit_valid_i high shall set exit_latched_o and capture exit_value_i[NUM_LEDS-1:0] into an exit register on the same edge.
REQ-025 Once latched, further exit_valid_i pulses shall be ignored; only reset shall clear the latch.
REQ-026 While exit_latched_o = 1, led_o shall equal the captured exit bits, overriding all modes, from the cycle after latching.
REQ-027 While exit_latched_o = 1, the prescaler and heartbeat_o shall keep running.
REQ-028 Each LED channel's behaviour shall depend only on its own mode, event and stretch counter, plus the shared phase and exit state.

Reset
REQ-029 While rst_ni = 0, the following shall be cleared asynchronously to 0: led_o, heartbeat_o, exit_latched_o, the prescaler, the phase, all stretch counters and the exit register.
REQ-030 Reset asserted mid-stretch or mid-blink shall abort the operation with no residual state.
REQ-031 After rst_ni is released, the first prescaler increment shall occur on the first clk_i rising edge.

Verification
REQ-032 Blink: NUM_LEDS = 4, mode = 10 on all channels, cfg_div_i = 3 -> led_o toggles 0000/1111 every 4 cycles, in step with heartbeat_o.
REQ-033 Stretch: channel 1 in mode 11, cfg_div_i = 0, STRETCH_TICKS = 8, a 1-cycle event -> led_o[1] high for exactly 8 cycles, starting 1 cycle after the reload.
REQ-034 Retrigger plus coincidence: with the stretch counter at 2 and event and tick in the same cycle -> counter reads 8, not 7; LED stays high 8 more ticks.
REQ-035 Exit: exit_valid_i pulse with exit_value_i = 0x0000_000A -> exit_latched_o = 1 and led_o = 1010 next cycle; a second pulse with 0x5 -> no change.
REQ-036 Divider shrink: count at 20, cfg_div_i changed from 100 to 5 -> tick next cycle, then period of 6 cycles.
REQ-037 Reset mid-operation: rst_ni low during active stretch and exit latch -> all outputs 0 immediately, without waiting for a clock edge; after release, channel modes resume from count 0.

Source files
------------

// File: rtl/fpga_status_leds.sv
// Status LED driver: a shared tick prescaler and blink phase, per-channel OFF/ON/BLINK/STRETCH
// modes, and a sticky program-exit latch that takes over the LEDs once set.
module fpga_status_leds #(
   parameter int NUM_LEDS      = 4,
   parameter int DIV_W         = 27,
   parameter int STRETCH_W     = 4,
   parameter int STRETCH_TICKS = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [2*NUM_LEDS-1:0] cfg_mode_i,
   input  logic [DIV_W-1:0]      cfg_div_i,
   input  logic [NUM_LEDS-1:0]   event_i,
   input  logic                  exit_valid_i,
   input  logic [31:0]           exit_value_i,
   output logic [NUM_LEDS-1:0]   led_o,
   output logic                  heartbeat_o,
   output logic                  exit_latched_o
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_STRETCH = 2'b11
   } mode_e;

   localparam logic [STRETCH_W-1:0] RELOAD = STRETCH_W'(STRETCH_TICKS);

   logic [DIV_W-1:0]                   div_q, div_d;
   logic                               tick;
   logic                               phase_q, phase_d;
   logic [NUM_LEDS-1:0][STRETCH_W-1:0] cnt_q, cnt_d;
   logic [NUM_LEDS-1:0]                led_q, led_d;
   logic [NUM_LEDS-1:0]                exit_q, exit_d;
   logic                               lat_q, lat_d;
   logic                               unused_exit_bits;

   // Comparing with >= lets a shrinking divider fire on the very next cycle.
   assign tick = (div_q >= cfg_div_i);

   always_comb begin
      div_d   = tick ? '0 : div_q + DIV_W'(1);
      phase_d = phase_q ^ tick;
      lat_d   = lat_q | exit_valid_i;
      exit_d  = (exit_valid_i && !lat_q) ? exit_value_i[NUM_LEDS-1:0] : exit_q;
      cnt_d   = '0;
      led_d   = '0;
      for (int k = 0; k < NUM_LEDS; k++) begin
         case (mode_e'(cfg_mode_i[2*k +: 2]))
            MODE_OFF:   led_d[k] = 1'b0;
            MODE_ON:    led_d[k] = 1'b1;
            MODE_BLINK: led_d[k] = phase_q;
            default: begin
               // Reload has priority over a coincident tick decrement.
               if (event_i[k])
                  cnt_d[k] = RELOAD;
               else if (tick && cnt_q[k] != '0)
                  cnt_d[k] = cnt_q[k] - STRETCH_W'(1);
               else
                  cnt_d[k] = cnt_q[k];
               led_d[k] = (cnt_q[k] != '0);
            end
         endcase
      end
      if (lat_q)
         led_d = exit_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q   <= '0;
         phase_q <= 1'b0;
         cnt_q   <= '0;
         led_q   <= '0;
         exit_q  <= '0;
         lat_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         exit_q  <= exit_d;
         lat_q   <= lat_d;
      end
   end

   generate
      if (NUM_LEDS < 32) begin : g_unused
         assign unused_exit_bits = ^exit_value_i[31:NUM_LEDS];
      end else begin : g_all_used
         assign unused_exit_bits = 1'b0;
      end
   endgenerate

   assign led_o          = led_q;
   assign heartbeat_o    = phase_q;
   assign exit_latched_o = lat_q;

endmodule

// File: tb/tb_fpga_status_leds.sv
// Bench for fpga_status_leds: a static-mode vector table plus hand-derived multi-cycle
// sequences for blink, stretch, retrigger, exit latch, divider shrink and async reset.
module tb_fpga_status_leds;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  mode;
   logic [26:0] div;
   logic [3:0]  ev;
   logic        xv;
   logic [31:0] xval;
   logic [3:0]  led;
   logic        hb;
   logic        lat;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] led;
      logic       hb;
      logic       lat;
      string      name;
   } exp_t;

   typedef struct {
      logic [7:0] mode;
      logic [3:0] ev;
      logic [3:0] led;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[14];

   fpga_status_leds #(
      .NUM_LEDS(4), .DIV_W(27), .STRETCH_W(4), .STRETCH_TICKS(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .cfg_mode_i(mode), .cfg_div_i(div),
      .event_i(ev), .exit_valid_i(xv), .exit_value_i(xval),
      .led_o(led), .heartbeat_o(hb), .exit_latched_o(lat)
   );

   always #5 clk = ~clk;

   task automatic check_now(input string name, input logic [3:0] e_led,
                            input logic e_hb, input logic e_lat);
      n_vec++;
      if (led !== e_led || hb !== e_hb || lat !== e_lat) begin
         n_err++;
         $display("FAIL %s: got led=%b hb=%b lat=%b, want led=%b hb=%b lat=%b",
                  name, led, hb, lat, e_led, e_hb, e_lat);
      end
   endtask

   // Expected values go in when the cycle's stimulus is driven and come out after the edge.
   task automatic step(input string name, input logic [3:0] e_led,
                       input logic e_hb, input logic e_lat);
      exp_t e;
      e.led = e_led; e.hb = e_hb; e.lat = e_lat; e.name = name;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      check_now(e.name, e.led, e.hb, e.lat);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic       p_hb;
      logic       e_hb;
      logic [3:0] e_led;

      rst_n = 1'b0; mode = 8'h00; div = 27'd1000; ev = 4'h0; xv = 1'b0; xval = 32'h0;
      #2;
      check_now("reset_state", 4'h0, 1'b0, 1'b0);

      tbl[0]  = '{8'h00, 4'h0, 4'b0000};
      tbl[1]  = '{8'h55, 4'h0, 4'b1111};
      tbl[2]  = '{8'h11, 4'h0, 4'b0101};
      tbl[3]  = '{8'hAA, 4'h0, 4'b0000};
      tbl[4]  = '{8'hFF, 4'h0, 4'b0000};
      tbl[5]  = '{8'hFF, 4'h2, 4'b0000};
      tbl[6]  = '{8'hFF, 4'h0, 4'b0010};
      tbl[7]  = '{8'hFF, 4'h0, 4'b0010};
      tbl[8]  = '{8'hF3, 4'hF, 4'b0000};
      tbl[9]  = '{8'hFF, 4'h0, 4'b1101};
      tbl[10] = '{8'h00, 4'h0, 4'b0000};
      tbl[11] = '{8'hFF, 4'h0, 4'b0000};
      tbl[12] = '{8'h40, 4'hF, 4'b1000};
      tbl[13] = '{8'hFF, 4'h0, 4'b0000};

      do_reset();
      for (int i = 0; i < 14; i++) begin
         mode = tbl[i].mode;
         ev   = tbl[i].ev;
         step($sformatf("table[%0d]", i), tbl[i].led, 1'b0, 1'b0);
      end
      ev = 4'h0;

      // Blink, period-4 ticks
      mode = 8'hAA; div = 27'd3;
      do_reset();
      for (int n = 1; n <= 16; n++)
         step($sformatf("blink[%0d]", n), (((n - 1) / 4) % 2) ? 4'hF : 4'h0,
              1'((n / 4) % 2), 1'b0);

      // Single stretch pulse on channel 1
      mode = 8'h0C; div = 27'd0;
      do_reset();
      for (int n = 1; n <= 11; n++) begin
         ev = (n == 1) ? 4'h2 : 4'h0;
         step($sformatf("stretch[%0d]", n), (n >= 2 && n <= 9) ? 4'h2 : 4'h0,
              1'(n % 2), 1'b0);
      end

      // Retrigger coinciding with a tick while the counter holds 2
      do_reset();
      for (int n = 1; n <= 18; n++) begin
         ev = (n == 1 || n == 8) ? 4'h2 : 4'h0;
         step($sformatf("retrig[%0d]", n), (n >= 2 && n <= 16) ? 4'h2 : 4'h0,
              1'(n % 2), 1'b0);
      end
      ev = 4'h0;

      // Exit latch, second pulse ignored, heartbeat keeps running
      div = 27'd1;
      mode = 8'h55;
      do_reset();
      for (int n = 1; n <= 6; n++) begin
         xv   = (n == 1 || n == 3);
         xval = (n == 1) ? 32'h0000_000A : 32'h0000_0005;
         mode = (n >= 5) ? 8'h00 : 8'h55;
         step($sformatf("exit[%0d]", n), (n == 1) ? 4'hF : 4'hA,
              1'((n / 2) % 2), 1'b1);
      end
      xv = 1'b0;

      // Divider shrinks from 100 to 5 with the count at 20
      mode = 8'hAA; div = 27'd100;
      do_reset();
      p_hb = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         if (n == 21) div = 27'd5;
         e_hb  = (n < 21) ? 1'b0 : ((((n - 21) / 6) % 2) == 0);
         e_led = p_hb ? 4'hF : 4'h0;
         step($sformatf("shrink[%0d]", n), e_led, e_hb, 1'b0);
         p_hb = e_hb;
      end

      // Asynchronous reset during an active stretch and a latched exit
      mode = 8'hFF; div = 27'd0;
      do_reset();
      ev = 4'hF;
      step("rstmid[1]", 4'h0, 1'b1, 1'b0);
      ev = 4'h0; xv = 1'b1; xval = 32'h0000_0006;
      step("rstmid[2]", 4'hF, 1'b0, 1'b1);
      xv = 1'b0;
      step("rstmid[3]", 4'h6, 1'b1, 1'b1);
      rst_n = 1'b0;
      #2;
      check_now("async_clear", 4'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("resume[1]", 4'h0, 1'b1, 1'b0);
      mode = 8'h55;
      step("resume[2]", 4'hF, 1'b0, 1'b0);
      step("resume[3]", 4'hF, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
